// File: rtl/dbg_run_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dbg_run_pkg: op, halt-cause and state encodings for dbg_run_ctrl |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dbg_run_pkg;

  typedef enum logic [2:0] {
    OP_HALT   = 3'd0,
    OP_RUN    = 3'd1,
    OP_STEP   = 3'd2,
    OP_SET_BP = 3'd3,
    OP_CLR_BP = 3'd4
  } cmd_op_t;

  typedef enum logic [2:0] {
    CAUSE_NONE       = 3'd0,
    CAUSE_CMD        = 3'd1,
    CAUSE_STEP_DONE  = 3'd2,
    CAUSE_BREAKPOINT = 3'd3,
    CAUSE_EXT        = 3'd4
  } halt_cause_t;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } state_t;

  // RUN and STEP are only meaningful once the core is halted.
  function automatic logic op_needs_halt(input logic [2:0] op);
    return (op == OP_RUN) || (op == OP_STEP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_bp_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dbg_bp_unit: single PC breakpoint with skip-once after resume    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dbg_bp_unit
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            set_bp,
  input  logic            clr_bp,
  input  logic [XLEN-1:0] bp_arg,
  input  logic            arm_skip,
  input  logic            active,
  input  logic [XLEN-1:0] pc,
  output logic            bp_hit,
  output logic            bp_active
);

  logic [XLEN-1:0] r_bp_addr;
  logic            r_bp_active;
  logic            r_skip;

  assign bp_hit    = r_bp_active && (pc == r_bp_addr) && !r_skip && active;
  assign bp_active = r_bp_active;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_bp_addr   <= '0;
      r_bp_active <= 1'b0;
      r_skip      <= 1'b0;
    end else begin
      if (set_bp) begin
        r_bp_addr   <= bp_arg;
        r_bp_active <= 1'b1;
      end else if (clr_bp) begin
        r_bp_active <= 1'b0;
      end
      // Skip lasts until the first enabled core cycle after a resume.
      if (arm_skip) begin
        r_skip <= 1'b1;
      end else if (active && !bp_hit) begin
        r_skip <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dbg_run_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dbg_run_ctrl: run/halt/step sequencer driving the core clock en  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dbg_run_ctrl
  import dbg_run_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STEP_W       = 16,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic            sysclk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [XLEN-1:0] cmd_arg,
  input  logic            ext_halt_req,
  input  logic [XLEN-1:0] pc,
  output logic            core_clk_en,
  output logic            halted,
  output logic [2:0]      halt_cause,
  output logic            bp_active,
  output logic [31:0]     cycle_count
);

  localparam state_t RESET_STATE = RUN_ON_RESET ? ST_RUNNING : ST_HALTED;

  state_t            r_state,    w_state_nxt;
  halt_cause_t       r_cause,    w_cause_nxt;
  logic [STEP_W-1:0] r_step_cnt, w_step_cnt_nxt;
  logic [31:0]       r_cycle_count;
  logic              r_halted;
  logic              w_active;
  logic              w_cmd_fire;
  logic              w_bp_hit;
  logic              w_set_bp;
  logic              w_clr_bp;
  logic              w_arm_skip;
  logic [STEP_W-1:0] w_step_arg;

  assign w_active    = (r_state != ST_HALTED);
  assign w_step_arg  = cmd_arg[STEP_W-1:0];
  assign cmd_ready   = !w_active || !op_needs_halt(cmd_op);
  assign w_cmd_fire  = cmd_valid && cmd_ready;
  assign w_set_bp    = w_cmd_fire && (cmd_op == OP_SET_BP);
  assign w_clr_bp    = w_cmd_fire && (cmd_op == OP_CLR_BP);
  assign core_clk_en = w_active && !w_bp_hit;

  assign halted      = r_halted;
  assign halt_cause  = r_cause;
  assign cycle_count = r_cycle_count;

  dbg_bp_unit #(
    .XLEN (XLEN)
  ) u_bp_unit (
    .sysclk    (sysclk),
    .reset     (reset),
    .set_bp    (w_set_bp),
    .clr_bp    (w_clr_bp),
    .bp_arg    (cmd_arg),
    .arm_skip  (w_arm_skip),
    .active    (w_active),
    .pc        (pc),
    .bp_hit    (w_bp_hit),
    .bp_active (bp_active)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cause_nxt    = r_cause;
    w_step_cnt_nxt = r_step_cnt;
    w_arm_skip     = 1'b0;
    case (r_state)
      ST_HALTED: begin
        if (w_cmd_fire && (cmd_op == OP_RUN)) begin
          w_state_nxt = ST_RUNNING;
          w_cause_nxt = CAUSE_NONE;
          w_arm_skip  = 1'b1;
        end else if (w_cmd_fire && (cmd_op == OP_STEP) && (w_step_arg != '0)) begin
          w_state_nxt    = ST_STEPPING;
          w_cause_nxt    = CAUSE_NONE;
          w_step_cnt_nxt = w_step_arg;
          w_arm_skip     = 1'b1;
        end
      end
      default: begin
        if ((r_state == ST_STEPPING) && core_clk_en) begin
          w_step_cnt_nxt = r_step_cnt - STEP_W'(1);
          if (r_step_cnt == STEP_W'(1)) begin
            w_state_nxt = ST_HALTED;
            w_cause_nxt = CAUSE_STEP_DONE;
          end
        end
        // Later assignments win: lowest-priority halt source first.
        if (w_cmd_fire && (cmd_op == OP_HALT)) begin
          w_state_nxt = ST_HALTED;
          w_cause_nxt = CAUSE_CMD;
        end
        if (ext_halt_req) begin
          w_state_nxt = ST_HALTED;
          w_cause_nxt = CAUSE_EXT;
        end
        if (w_bp_hit) begin
          w_state_nxt = ST_HALTED;
          w_cause_nxt = CAUSE_BREAKPOINT;
        end
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state       <= RESET_STATE;
      r_halted      <= !RUN_ON_RESET;
      r_cause       <= CAUSE_NONE;
      r_step_cnt    <= '0;
      r_cycle_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_halted   <= (w_state_nxt == ST_HALTED);
      r_cause    <= w_cause_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      if (core_clk_en) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbg_run_ctrl.sv
`default_nettype none
// tb_dbg_run_ctrl: free-run and halted-at-reset instances checked every cycle
// against a behavioural run/step/breakpoint model, plus literal pins.
module tb_dbg_run_ctrl;

  logic              sysclk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic [31:0]       cmd_arg;
  logic              ext_halt_req;
  logic [1:0][31:0]  pc_r;
  logic [1:0]        rdy_o, en_o, halted_o, bp_o;
  logic [1:0][2:0]   cause_o;
  logic [1:0][31:0]  cc_o;

  int checks   = 0;
  int failures = 0;

  // Model state per instance (0: runs from reset, 1: halted at reset).
  bit          m_halted [2];
  int unsigned m_steps  [2];   // 0 = free run, else remaining steps
  bit          m_skip   [2];
  bit          m_bp_on  [2];
  logic [31:0] m_bp     [2];
  int          m_cause  [2];
  logic [31:0] m_cycles [2];
  bit          adv      [2];

  always #5 sysclk = ~sysclk;

  dbg_run_ctrl #(.XLEN(32), .STEP_W(16), .RUN_ON_RESET(1'b1)) u_dut_run (
    .sysclk(sysclk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy_o[0]),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ext_halt_req(ext_halt_req), .pc(pc_r[0]),
    .core_clk_en(en_o[0]), .halted(halted_o[0]), .halt_cause(cause_o[0]),
    .bp_active(bp_o[0]), .cycle_count(cc_o[0])
  );

  dbg_run_ctrl #(.XLEN(32), .STEP_W(16), .RUN_ON_RESET(1'b0)) u_dut_halt (
    .sysclk(sysclk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy_o[1]),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ext_halt_req(ext_halt_req), .pc(pc_r[1]),
    .core_clk_en(en_o[1]), .halted(halted_o[1]), .halt_cause(cause_o[1]),
    .bp_active(bp_o[1]), .cycle_count(cc_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Compare process: one sample per cycle, 1 time unit before the rising edge.
  always @(negedge sysclk) begin
    bit hit, en, ready, fire;
    int sc;
    #4;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_halted[i] = (i == 1);
        m_steps[i]  = 0;
        m_skip[i]   = 1'b0;
        m_bp_on[i]  = 1'b0;
        m_bp[i]     = 32'd0;
        m_cause[i]  = 0;
        m_cycles[i] = 32'd0;
      end
      hit   = m_bp_on[i] && (pc_r[i] == m_bp[i]) && !m_skip[i] && !m_halted[i];
      en    = !m_halted[i] && !hit;
      ready = m_halted[i] || ((cmd_op != 3'd1) && (cmd_op != 3'd2));
      fire  = cmd_valid && ready;
      chk($sformatf("core_clk_en[%0d]", i), 32'(en_o[i]), 32'(en));
      chk($sformatf("cmd_ready[%0d]", i), 32'(rdy_o[i]), 32'(ready));
      chk($sformatf("halted[%0d]", i), 32'(halted_o[i]), 32'(m_halted[i]));
      chk($sformatf("halt_cause[%0d]", i), 32'(cause_o[i]), 32'(m_cause[i]));
      chk($sformatf("bp_active[%0d]", i), 32'(bp_o[i]), 32'(m_bp_on[i]));
      chk($sformatf("cycle_count[%0d]", i), cc_o[i], m_cycles[i]);
      adv[i] = 1'b0;
      if (!reset) begin
        adv[i] = en;
        if (en) begin
          m_cycles[i] = m_cycles[i] + 32'd1;
          m_skip[i]   = 1'b0;
        end
        if (fire && cmd_op == 3'd3) begin
          m_bp[i]    = cmd_arg;
          m_bp_on[i] = 1'b1;
        end
        if (fire && cmd_op == 3'd4) m_bp_on[i] = 1'b0;
        if (m_halted[i]) begin
          if (fire && cmd_op == 3'd1) begin
            m_halted[i] = 1'b0; m_steps[i] = 0; m_skip[i] = 1'b1; m_cause[i] = 0;
          end else if (fire && cmd_op == 3'd2 && cmd_arg[15:0] != 16'd0) begin
            m_halted[i] = 1'b0; m_steps[i] = cmd_arg[15:0]; m_skip[i] = 1'b1; m_cause[i] = 0;
          end
        end else begin
          sc = 0;
          if (en && m_steps[i] != 0) begin
            m_steps[i] = m_steps[i] - 1;
            if (m_steps[i] == 0) sc = 2;
          end
          if (fire && cmd_op == 3'd0) sc = 1;
          if (ext_halt_req) sc = 4;
          if (hit) sc = 3;
          if (sc != 0) begin
            m_halted[i] = 1'b1;
            m_cause[i]  = sc;
          end
        end
      end
    end
  end

  // PC of each core advances by 4 (within 0x00..0x3C) only after an enabled edge.
  task automatic drive(input bit v, input logic [2:0] op, input logic [31:0] arg, input bit ext);
    @(negedge sysclk);
    for (int i = 0; i < 2; i++)
      if (adv[i]) pc_r[i] = (pc_r[i] + 32'd4) & 32'h3C;
    cmd_valid    = v;
    cmd_op       = op;
    cmd_arg      = arg;
    ext_halt_req = ext;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    #2;
    reset        = 1'b1;
    pc_r         = '0;
    cmd_valid    = 1'b0;
    ext_halt_req = 1'b0;
    @(negedge sysclk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    logic [2:0]  op;
    logic [31:0] arg;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 32'd0;
    ext_halt_req = 1'b0; pc_r = '0;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;

    // Free-run from reset vs. halted at reset.
    idle(10);
    #1;
    chk("freerun_cycles", cc_o[0], 32'd10);
    chk("freerun_halted", 32'(halted_o[0]), 32'd0);
    chk("haltrst_halted", 32'(halted_o[1]), 32'd1);
    chk("haltrst_cycles", cc_o[1], 32'd0);

    // STEP 3 from halted.
    drive(1'b1, 3'd2, 32'd3, 1'b0);
    idle(1); #1;
    chk("step3_en_first", 32'(en_o[1]), 32'd1);
    idle(3); #1;
    chk("step3_halted", 32'(halted_o[1]), 32'd1);
    chk("step3_cause", 32'(cause_o[1]), 32'd2);
    chk("step3_cycles", cc_o[1], 32'd3);
    chk("step3_en_off", 32'(en_o[1]), 32'd0);

    // Breakpoint at 0x10, then resume past it.
    do_reset();
    drive(1'b1, 3'd3, 32'h10, 1'b0);
    drive(1'b1, 3'd1, 32'd0, 1'b0);
    idle(5); #1;
    chk("bp_en_at_0x10", 32'(en_o[1]), 32'd0);
    idle(1); #1;
    chk("bp_halted", 32'(halted_o[1]), 32'd1);
    chk("bp_cause", 32'(cause_o[1]), 32'd3);
    chk("bp_cycles", cc_o[1], 32'd4);
    drive(1'b1, 3'd1, 32'd0, 1'b0);
    idle(2); #1;
    chk("bp_resume_running", 32'(halted_o[1]), 32'd0);
    chk("bp_resume_cycles", cc_o[1], 32'd5);

    // RUN while running is held off; HALT coinciding with breakpoint hit.
    drive(1'b1, 3'd1, 32'd0, 1'b0); #1;
    chk("run_ready_while_running", 32'(rdy_o[1]), 32'd0);
    n = 0;
    do begin
      idle(1);
      n++;
    end while (pc_r[1] != 32'h10 && n < 40);
    chk("wait_pc_bp", pc_r[1], 32'h10);
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    idle(1); #1;
    chk("halt_vs_bp_cause", 32'(cause_o[1]), 32'd3);
    chk("halt_vs_bp_halted", 32'(halted_o[1]), 32'd1);
    chk("halt_vs_bp_cycles", cc_o[1], 32'd20);

    // STEP 0 is a no-op; STEP 5 cut short by external halt on step 2.
    drive(1'b1, 3'd2, 32'd0, 1'b0);
    idle(1); #1;
    chk("step0_halted", 32'(halted_o[1]), 32'd1);
    chk("step0_cause", 32'(cause_o[1]), 32'd3);
    chk("step0_cycles", cc_o[1], 32'd20);
    drive(1'b1, 3'd2, 32'd5, 1'b0);
    drive(1'b0, 3'd0, 32'd0, 1'b0);
    drive(1'b0, 3'd0, 32'd0, 1'b1);
    drive(1'b0, 3'd0, 32'd0, 1'b0); #1;
    chk("step5_ext_halted", 32'(halted_o[1]), 32'd1);
    chk("step5_ext_cause", 32'(cause_o[1]), 32'd4);
    chk("step5_ext_cycles", cc_o[1], 32'd22);

    // Asynchronous reset in the middle of a STEP 10 (7 steps left).
    drive(1'b1, 3'd2, 32'd10, 1'b0);
    idle(4);
    #2;
    reset = 1'b1;
    pc_r  = '0;
    #1;
    chk("rst_mid_en", 32'(en_o[1]), 32'd0);
    chk("rst_mid_halted", 32'(halted_o[1]), 32'd1);
    chk("rst_mid_cause", 32'(cause_o[1]), 32'd0);
    chk("rst_mid_bp", 32'(bp_o[1]), 32'd0);
    chk("rst_mid_cycles", cc_o[1], 32'd0);
    chk("rst_mid_run_halted", 32'(halted_o[0]), 32'd0);
    chk("rst_mid_run_cycles", cc_o[0], 32'd0);
    @(negedge sysclk);
    reset = 1'b0;

    // Randomized commands, external halts and occasional resets.
    for (int k = 0; k < 4000; k++) begin
      r = int'($urandom_range(0, 199));
      if (r < 1) begin
        do_reset();
      end else begin
        op = 3'($urandom_range(0, 7));
        case (op)
          3'd2:    arg = {16'($urandom), 16'($urandom_range(0, 6))};
          3'd3:    arg = 32'($urandom_range(0, 15)) << 2;
          default: arg = $urandom;
        endcase
        drive(r < 30, op, arg, $urandom_range(0, 39) == 0);
      end
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dbg_run_ctrl.md
Name: dbg_run_ctrl

Overview:
- Run/halt sequencer for the RISC-V core in the JTAG drop-in-test top.
- Produces the clock-enable that gates sysclk into the core's debug clock.
- Accepts debug commands: halt, run, step-N, set/clear breakpoint.
- Halts the core on a PC breakpoint or an external halt request, and reports status and executed-cycle count.

Parameters:
- XLEN, 32, width of PC and command argument
- STEP_W, 16, width of step counter; STEP uses cmd_arg[STEP_W-1:0]
- RUN_ON_RESET, 1, 1 = core free-runs after reset; 0 = core comes out of reset halted

Ports:
- sysclk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  3  0 HALT, 1 RUN, 2 STEP, 3 SET_BP, 4 CLR_BP; 5-7 reserved
- cmd_arg  in  XLEN  step count (STEP) or breakpoint address (SET_BP)
- ext_halt_req  in  1  level halt request, e.g. from test success/fail
- pc  in  XLEN  core fetch PC (PCF); changes only after an enabled core edge
- core_clk_en  out  1  enable to the clock gate; core advances one cycle per sysclk cycle with en=1
- halted  out  1  state == HALTED
- halt_cause  out  3  0 NONE, 1 CMD, 2 STEP_DONE, 3 BREAKPOINT, 4 EXT
- bp_active  out  1  breakpoint armed
- cycle_count  out  32  number of enabled core cycles since reset

Behaviour:
- Reset (asynchronous, active-high; clock sysclk):
  - state = RUNNING if RUN_ON_RESET, else HALTED; halted = !RUN_ON_RESET.
  - halt_cause = NONE; cycle_count = 0; bp_active = 0; bp_addr = 0; step_cnt = 0; skip = 0.
  - Reset asserted mid-run or mid-step aborts immediately to these values.
- States: HALTED, RUNNING, STEPPING. All registered; outputs other than core_clk_en and cmd_ready are registered.
- cmd_ready (combinational):
  - 1 in HALTED for all ops.
  - In RUNNING/STEPPING: 1 for HALT, SET_BP, CLR_BP and reserved ops; 0 for RUN and STEP (held off until halted).
- Command handling:
  - Reserved ops are accepted and ignored.
  - SET_BP: bp_addr <= cmd_arg, bp_active <= 1. CLR_BP: bp_active <= 0. Both take effect for compares from the next cycle.
  - RUN in HALTED: state <= RUNNING, skip <= 1, halt_cause <= NONE.
  - STEP N>0 in HALTED: state <= STEPPING, step_cnt <= N, skip <= 1, halt_cause <= NONE.
  - STEP N=0: accepted; state stays HALTED; halt_cause unchanged.
  - HALT in HALTED: no effect. HALT in RUNNING/STEPPING: state <= HALTED, cause CMD. core_clk_en is 0 from the cycle after acceptance.
- Breakpoint hit (combinational): bp_hit = bp_active && pc == bp_addr && !skip && state != HALTED.
- core_clk_en (combinational) = (state == RUNNING || state == STEPPING) && !bp_hit.
  - The core stops with PCF == bp_addr; the instruction at bp_addr is not yet executed.
  - skip clears after the first cycle with core_clk_en = 1, so RUN or STEP issued at a breakpoint PC moves past it.
- bp_hit while RUNNING/STEPPING: zero extra core cycles; state <= HALTED, cause BREAKPOINT.
- STEPPING:
  - step_cnt decrements on each enabled cycle.
  - On the enabled cycle where step_cnt == 1: state <= HALTED, cause STEP_DONE.
  - Exactly N core edges occur.
- ext_halt_req sampled high while RUNNING/STEPPING: same as HALT, cause EXT. While held high, RUN/STEP are accepted but re-halt next cycle after one core cycle.
- Simultaneous halt sources, cause priority: BREAKPOINT > EXT > CMD > STEP_DONE.
- cycle_count increments on every cycle with core_clk_en = 1; wraps 0xFFFFFFFF -> 0.

Decomposition:
- Package dbg_run_pkg: cmd_op_t, halt_cause_t and state_t enums; op/cause encodings above.
- One sub-module, dbg_bp_unit: bp_addr/bp_active registers, skip flag and comparator; outputs bp_hit.

Test Plan:
- RUN_ON_RESET=1, reset released, no commands -> core_clk_en = 1 every cycle; cycle_count = 10 after 10 cycles; halted = 0.
- RUN_ON_RESET=0, STEP arg=3 -> core_clk_en high exactly 3 cycles starting the cycle after acceptance; then halted = 1, halt_cause = 2, cycle_count = 3.
- SET_BP 0x0000_0010, RUN, pc walks 0x0,0x4,0x8,0xC,0x10 -> core_clk_en = 0 in the cycle pc = 0x10; halted = 1, cause = 3. Then RUN -> pc advances to 0x14 without re-halting at 0x10.
- RUNNING with HALT and bp_hit in the same cycle -> cause = 3 (BREAKPOINT); cmd_ready = 0 for a RUN presented while RUNNING.
- STEP arg=0 in HALTED -> accepted; no enabled cycles; state and cause unchanged. STEP arg=5 with ext_halt_req pulsed at step 2 -> 2 core cycles executed; cause = 4.
- Reset asserted mid-STEP (step_cnt = 7) -> outputs return to reset values asynchronously; bp_active = 0; cycle_count = 0.
